// File: rtl/psum_accumulator_if.sv
// Handshake bundle for the partial-sum accumulator: NUM_IN 4-phase input
// channels with flattened data, plus one 4-phase output channel.
interface psum_accumulator_if #(
    parameter int NUM_IN    = 2,
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_OUT = 13
) ();
    logic [NUM_IN-1:0]          L_req;
    logic [NUM_IN*WIDTH_IN-1:0] L_data;
    logic [NUM_IN-1:0]          L_ack;
    logic                       R_req;
    logic [WIDTH_OUT-1:0]       R_data;
    logic                       R_sat;
    logic                       R_ack;

    modport master (
        output L_req, L_data, R_ack,
        input  L_ack, R_req, R_data, R_sat
    );

    modport slave (
        input  L_req, L_data, R_ack,
        output L_ack, R_req, R_data, R_sat
    );
endinterface

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: gathers one token per input channel per round,
// accumulates NUM_ACC rounds with unsigned saturation, and hands the result
// to the membrane-potential stage over a 4-phase req/ack channel.
//
// state   | meaning
// --------+----------------------------------------------------------
// COLLECT | accepting input tokens; round end once every channel delivered
// SEND    | R_req high with registered sum/sat, waiting for R_ack
// DRAIN   | R_req low, waiting for R_ack to fall, then clear for next token
module psum_accumulator #(
    parameter int NUM_IN    = 2,
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_OUT = 13,
    parameter int NUM_ACC   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    psum_accumulator_if.slave bus
);

    localparam int TREE_W = WIDTH_IN + $clog2(NUM_IN);
    localparam int ACC_W  = WIDTH_OUT + 1;
    localparam int SUM_W  = ((ACC_W > TREE_W) ? ACC_W : TREE_W) + 1;
    localparam int CNT_W  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
    localparam logic [SUM_W-1:0] SAT_MAX = {{(SUM_W-WIDTH_OUT){1'b0}}, {WIDTH_OUT{1'b1}}};

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SEND    = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [NUM_IN-1:0]    got;
    logic [NUM_IN-1:0]    l_ack;
    logic [NUM_IN-1:0]    accept;
    logic [ACC_W-1:0]     acc;
    logic                 sat;
    logic [CNT_W-1:0]     rnd;
    logic                 r_req;
    logic [WIDTH_OUT-1:0] r_data;
    logic                 r_sat;
    logic [TREE_W-1:0]    tree_sum;
    logic [SUM_W-1:0]     acc_sum;
    logic                 acc_ovf;
    logic                 round_done;
    logic                 last_round;

    // Per-channel accept: new request, ack idle, channel not yet used this round.
    always_comb begin
        accept = '0;
        if (state == COLLECT)
            accept = bus.L_req & ~l_ack & ~got;
    end

    // One adder tree over every channel accepted on this edge, then saturation test.
    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (accept[i])
                tree_sum = tree_sum + TREE_W'(bus.L_data[i*WIDTH_IN +: WIDTH_IN]);
        end
        acc_sum    = SUM_W'(acc) + SUM_W'(tree_sum);
        acc_ovf    = (acc_sum > SAT_MAX);
        round_done = (state == COLLECT) && (&got);
        last_round = (rnd == CNT_W'(NUM_ACC - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= COLLECT;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (round_done && last_round) state_nxt = SEND;
            SEND:    if (bus.R_ack)                state_nxt = DRAIN;
            DRAIN:   if (!bus.R_ack)               state_nxt = COLLECT;
            default:                               state_nxt = COLLECT;
        endcase
    end

    // Datapath: input acks, accumulator, round bookkeeping and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_ack  <= '0;
            got    <= '0;
            acc    <= '0;
            sat    <= 1'b0;
            rnd    <= '0;
            r_req  <= 1'b0;
            r_data <= '0;
            r_sat  <= 1'b0;
        end else begin
            // an ack holds while its request is high; falls in any state
            l_ack <= (l_ack & bus.L_req) | accept;
            case (state)
                COLLECT: begin
                    if (round_done) begin
                        if (last_round) begin
                            r_req  <= 1'b1;
                            r_data <= acc[WIDTH_OUT-1:0];
                            r_sat  <= sat;
                        end else begin
                            rnd <= rnd + CNT_W'(1);
                            got <= '0;
                        end
                    end else if (|accept) begin
                        got <= got | accept;
                        acc <= acc_ovf ? ACC_W'(SAT_MAX) : acc_sum[ACC_W-1:0];
                        sat <= sat | acc_ovf;
                    end
                end
                SEND: begin
                    if (bus.R_ack) begin
                        r_req <= 1'b0;
                        r_sat <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!bus.R_ack) begin
                        acc <= '0;
                        sat <= 1'b0;
                        got <= '0;
                        rnd <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.L_ack  = l_ack;
    assign bus.R_req  = r_req;
    assign bus.R_data = r_data;
    assign bus.R_sat  = r_sat;

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: three instances (2x8->13 single round,
// 4x8->13 three rounds, 2x8->8 two rounds) driven by directed 4-phase
// stimulus; a sum/clamp model predicts each output token.
module tb_psum_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  lreq  [3];
    logic [7:0]  ldata [3][4];
    logic [2:0]  rack;
    logic [3:0]  lack  [3];
    logic [2:0]  rreq;
    logic [12:0] rdata [3];
    logic [2:0]  rsat;

    int checks   = 0;
    int failures = 0;
    int wout [3];

    psum_accumulator_if #(.NUM_IN(2), .WIDTH_IN(8), .WIDTH_OUT(13)) if0 ();
    psum_accumulator_if #(.NUM_IN(4), .WIDTH_IN(8), .WIDTH_OUT(13)) if1 ();
    psum_accumulator_if #(.NUM_IN(2), .WIDTH_IN(8), .WIDTH_OUT(8))  if2 ();

    assign if0.L_req  = lreq[0][1:0];
    assign if0.L_data = {ldata[0][1], ldata[0][0]};
    assign if0.R_ack  = rack[0];
    assign if1.L_req  = lreq[1];
    assign if1.L_data = {ldata[1][3], ldata[1][2], ldata[1][1], ldata[1][0]};
    assign if1.R_ack  = rack[1];
    assign if2.L_req  = lreq[2][1:0];
    assign if2.L_data = {ldata[2][1], ldata[2][0]};
    assign if2.R_ack  = rack[2];

    assign lack[0]  = {2'b00, if0.L_ack};
    assign lack[1]  = if1.L_ack;
    assign lack[2]  = {2'b00, if2.L_ack};
    assign rreq[0]  = if0.R_req;
    assign rreq[1]  = if1.R_req;
    assign rreq[2]  = if2.R_req;
    assign rdata[0] = if0.R_data;
    assign rdata[1] = if1.R_data;
    assign rdata[2] = {5'b00000, if2.R_data};
    assign rsat[0]  = if0.R_sat;
    assign rsat[1]  = if1.R_sat;
    assign rsat[2]  = if2.R_sat;

    psum_accumulator #(.NUM_IN(2), .WIDTH_IN(8), .WIDTH_OUT(13), .NUM_ACC(1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    psum_accumulator #(.NUM_IN(4), .WIDTH_IN(8), .WIDTH_OUT(13), .NUM_ACC(3))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    psum_accumulator #(.NUM_IN(2), .WIDTH_IN(8), .WIDTH_OUT(8),  .NUM_ACC(2))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    typedef struct {
        int dut;
        int data;
        bit sat;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Model: an output token is the plain total of every token of its
    // NUM_ACC rounds, clamped to the output range, with sat set if clamped.
    function automatic void push_expect(int d, int total);
        exp_t e;
        int maxv;
        maxv  = (1 << wout[d]) - 1;
        e.dut  = d;
        e.sat  = (total > maxv);
        e.data = e.sat ? maxv : total;
        exp_q.push_back(e);
    endfunction

    // Output monitor: checks every output token against the model and the
    // hold-stable rule while R_req is high.
    logic [2:0] prev_rreq = 3'b000;
    int  hold_data [3];
    bit  hold_sat  [3];
    int  last_data [3];
    bit  last_sat  [3];
    exp_t mon_e;

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rreq[d] && !prev_rreq[d]) begin
                if (exp_q.size() == 0 || exp_q[0].dut != d) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output dut=%0d data=%0d", d, rdata[d]);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", int'(rdata[d]), mon_e.data);
                    chk("out_sat", int'(rsat[d]), int'(mon_e.sat));
                end
                hold_data[d] <= int'(rdata[d]);
                hold_sat[d]  <= rsat[d];
                last_data[d] <= int'(rdata[d]);
                last_sat[d]  <= rsat[d];
            end else if (rreq[d]) begin
                chk("hold_data", int'(rdata[d]), hold_data[d]);
                chk("hold_sat", int'(rsat[d]), int'(hold_sat[d]));
            end else begin
                chk("sat_idle", int'(rsat[d]), 0);
            end
        end
        prev_rreq <= rreq;
    end

    task automatic wait_lack(int d, int ch, bit v);
        int n;
        n = 0;
        while (lack[d][ch] !== v && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (lack[d][ch] !== v) begin
            failures++;
            $display("FAIL wait_lack dut=%0d ch=%0d actual=%0b required=%0b", d, ch, lack[d][ch], v);
        end
    endtask

    task automatic wait_rreq(int d, bit v);
        int n;
        n = 0;
        while (rreq[d] !== v && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rreq[d] !== v) begin
            failures++;
            $display("FAIL wait_rreq dut=%0d actual=%0b required=%0b", d, rreq[d], v);
        end
    endtask

    task automatic send_tok(int d, int ch, int val);
        wait_lack(d, ch, 1'b0);
        ldata[d][ch] = val[7:0];
        lreq[d][ch]  = 1'b1;
        wait_lack(d, ch, 1'b1);
        lreq[d][ch]  = 1'b0;
        wait_lack(d, ch, 1'b0);
    endtask

    task automatic do_output(int d, int hold);
        wait_rreq(d, 1'b1);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("bp_lack", int'(lack[d]), 0);
            chk("bp_rreq", int'(rreq[d]), 1);
        end
        rack[d] = 1'b1;
        wait_rreq(d, 1'b0);
        chk("drain_lack", int'(lack[d]), 0);
        rack[d] = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    int rv [3][4];

    initial begin
        wout[0] = 13;
        wout[1] = 13;
        wout[2] = 8;
        rack = 3'b000;
        for (int d = 0; d < 3; d++) begin
            lreq[d] = 4'b0000;
            for (int c = 0; c < 4; c++) ldata[d][c] = 8'd0;
        end

        // reset values
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_lack", int'(lack[d]), 0);
            chk("rst_rreq", int'(rreq[d]), 0);
            chk("rst_rdata", int'(rdata[d]), 0);
            chk("rst_rsat", int'(rsat[d]), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // simultaneous arrival 100 + 27
        push_expect(0, 127);
        ldata[0][0] = 8'd100;
        ldata[0][1] = 8'd27;
        lreq[0]     = 4'b0011;
        @(negedge clk);
        chk("t1_ack", int'(lack[0]), 3);
        chk("t1_rreq_early", int'(rreq[0]), 0);
        @(negedge clk);
        chk("t1_rreq", int'(rreq[0]), 1);
        lreq[0] = 4'b0000;
        do_output(0, 0);
        chk("t1_lit_data", last_data[0], 127);
        chk("t1_lit_sat", int'(last_sat[0]), 0);

        // four channels, three rounds
        rv = '{'{1, 2, 3, 4}, '{10, 20, 30, 40}, '{5, 5, 5, 5}};
        push_expect(1, 1+2+3+4 + 10+20+30+40 + 5+5+5+5);
        for (int r = 0; r < 3; r++) begin
            fork
                send_tok(1, 0, rv[r][0]);
                send_tok(1, 1, rv[r][1]);
                send_tok(1, 2, rv[r][2]);
                send_tok(1, 3, rv[r][3]);
            join
            if (r < 2) begin
                repeat (3) begin
                    @(negedge clk);
                    chk("t2_no_early_req", int'(rreq[1]), 0);
                end
            end
        end
        do_output(1, 0);
        chk("t2_lit_data", last_data[1], 130);

        // stall of a re-requesting channel plus back-pressure
        push_expect(0, 50 + 70);
        push_expect(0, 60 + 9);
        send_tok(0, 0, 50);
        ldata[0][0] = 8'd60;
        lreq[0][0]  = 1'b1;
        repeat (3) @(negedge clk);
        chk("t3_stall_lack", int'(lack[0][0]), 0);
        send_tok(0, 1, 70);
        ldata[0][1] = 8'd9;
        lreq[0][1]  = 1'b1;
        do_output(0, 10);
        chk("t3_lit_data", last_data[0], 120);
        wait_lack(0, 0, 1'b1);
        wait_lack(0, 1, 1'b1);
        lreq[0] = 4'b0000;
        wait_lack(0, 0, 1'b0);
        wait_lack(0, 1, 1'b0);
        do_output(0, 0);
        chk("t3_lit_next", last_data[0], 69);

        // wide sum without clamp
        push_expect(0, 255 + 255);
        fork
            send_tok(0, 0, 255);
            send_tok(0, 1, 255);
        join
        do_output(0, 0);
        chk("t4_lit_data", last_data[0], 510);
        chk("t4_lit_sat", int'(last_sat[0]), 0);

        // clamp on an 8-bit output over two rounds
        push_expect(2, 200 + 100 + 1 + 1);
        fork
            send_tok(2, 0, 200);
            send_tok(2, 1, 100);
        join
        fork
            send_tok(2, 0, 1);
            send_tok(2, 1, 1);
        join
        do_output(2, 0);
        chk("t5_lit_data", last_data[2], 255);
        chk("t5_lit_sat", int'(last_sat[2]), 1);

        // asynchronous reset mid-round; held request becomes a new token
        ldata[0][0] = 8'd77;
        lreq[0][0]  = 1'b1;
        wait_lack(0, 0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_lack", int'(lack[0]), 0);
        chk("t6_rst_rreq", int'(rreq[0]), 0);
        chk("t6_rst_rdata", int'(rdata[0]), 0);
        chk("t6_rst_rsat", int'(rsat[0]), 0);
        ldata[0][0] = 8'd3;
        @(negedge clk);
        rst_n = 1'b1;
        push_expect(0, 3 + 4);
        fork
            send_tok(0, 1, 4);
            begin
                wait_lack(0, 0, 1'b1);
                lreq[0][0] = 1'b0;
                wait_lack(0, 0, 1'b0);
            end
        join
        do_output(0, 0);
        chk("t6_lit_data", last_data[0], 7);

        chk("model_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
